// File: rtl/rtc_access_scheduler.sv
// Scheduler for the RTC bus engine: periodic 9-register refresh bursts plus prioritised single writes.
// Optional macro RTC_TIMEOUT_EN adds a bus_done watchdog with a sticky bus_err flag.
module rtc_access_scheduler #(
    parameter int         REFRESH_DIV = 100000,
    parameter logic [7:0] ADDR_TIME   = 8'h21,
    parameter logic [7:0] ADDR_DATE   = 8'h24,
    parameter logic [7:0] ADDR_CRONO  = 8'h41
`ifdef RTC_TIMEOUT_EN
    , parameter int       TIMEOUT     = 4095
`endif
) (
    input  logic       reloj_nexys,
    input  logic       reset_total,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    output logic       bus_start,
    output logic       bus_rw,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    input  logic [7:0] bus_rdata,
    input  logic       bus_done,
    output logic [7:0] h_oro,
    output logic [7:0] m_oro,
    output logic [7:0] s_oro,
    output logic [7:0] giorno,
    output logic [7:0] messe,
    output logic [7:0] agno,
    output logic [7:0] ora,
    output logic [7:0] minute,
    output logic [7:0] secondo,
    output logic       snap_valid,
    output logic       bus_err
);

    localparam int CNT_W = $clog2(REFRESH_DIV);

    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, COMMIT, WR_ISSUE, WR_WAIT} state_t;

    state_t           state_reg;
    logic [3:0]       idx_reg;
    logic [CNT_W-1:0] refresh_cnt_reg;
    logic             refresh_pend_reg;
    logic             bus_start_reg;
    logic             bus_rw_reg;
    logic [7:0]       bus_addr_reg;
    logic [7:0]       bus_wdata_reg;
    logic             wr_ack_reg;
    logic             snap_valid_reg;
    logic [7:0]       shadow_reg [0:7];
    logic [7:0]       snap_reg   [0:8];
    logic [7:0]       addr_table [0:8];

    logic refresh_wrap;
    logic write_wanted;
    logic take_refresh;
    logic rd_capture;
    logic rd_commit;
    logic timed_out;

    // Burst order: time s/m/h, date d/mo/y, chrono s/m/h.
    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_addr_table
            localparam logic [7:0] BASE = (gi < 3) ? ADDR_TIME :
                                          (gi < 6) ? ADDR_DATE : ADDR_CRONO;
            assign addr_table[gi] = BASE + 8'(gi % 3);
        end
    endgenerate

    // A write seen in the wr_ack cycle is the one just completed, not a new one.
    assign write_wanted = wr_req && !wr_ack_reg;
    assign refresh_wrap = (refresh_cnt_reg == CNT_W'(REFRESH_DIV - 1));
    assign take_refresh = (state_reg == IDLE) && !write_wanted && refresh_pend_reg;
    assign rd_capture   = (state_reg == RD_WAIT) && bus_done;
    assign rd_commit    = rd_capture && (idx_reg == 4'd8);

    always_ff @(posedge reloj_nexys) begin
        if (reset_total) begin
            refresh_cnt_reg  <= '0;
            refresh_pend_reg <= 1'b0;
        end else begin
            refresh_cnt_reg <= refresh_wrap ? '0 : refresh_cnt_reg + 1'b1;
            if (refresh_wrap)
                refresh_pend_reg <= 1'b1;
            else if (take_refresh)
                refresh_pend_reg <= 1'b0;
        end
    end

`ifdef RTC_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] wait_cnt_reg;
    logic             bus_err_reg;
    logic             in_wait;

    assign in_wait   = (state_reg == RD_WAIT) || (state_reg == WR_WAIT);
    assign timed_out = in_wait && !bus_done && (wait_cnt_reg == TMO_W'(TIMEOUT - 1));
    assign bus_err   = bus_err_reg;

    always_ff @(posedge reloj_nexys) begin
        if (reset_total) begin
            wait_cnt_reg <= '0;
            bus_err_reg  <= 1'b0;
        end else begin
            if (in_wait && !bus_done && !timed_out)
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            else
                wait_cnt_reg <= '0;
            if (timed_out)
                bus_err_reg <= 1'b1;
        end
    end
`else
    assign timed_out = 1'b0;
    assign bus_err   = 1'b0;
`endif

    always_ff @(posedge reloj_nexys) begin
        if (reset_total) begin
            state_reg      <= IDLE;
            idx_reg        <= 4'd0;
            bus_start_reg  <= 1'b0;
            bus_rw_reg     <= 1'b0;
            bus_addr_reg   <= 8'h00;
            bus_wdata_reg  <= 8'h00;
            wr_ack_reg     <= 1'b0;
            snap_valid_reg <= 1'b0;
        end else begin
            bus_start_reg  <= 1'b0;
            wr_ack_reg     <= 1'b0;
            snap_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (write_wanted) begin
                        state_reg     <= WR_ISSUE;
                        bus_start_reg <= 1'b1;
                        bus_rw_reg    <= 1'b0;
                        bus_addr_reg  <= wr_addr;
                        bus_wdata_reg <= wr_data;
                    end else if (refresh_pend_reg) begin
                        state_reg     <= RD_ISSUE;
                        idx_reg       <= 4'd0;
                        bus_start_reg <= 1'b1;
                        bus_rw_reg    <= 1'b1;
                        bus_addr_reg  <= addr_table[0];
                    end
                end
                RD_ISSUE: state_reg <= RD_WAIT;
                RD_WAIT: begin
                    if (timed_out) begin
                        state_reg <= IDLE;
                    end else if (bus_done) begin
                        if (idx_reg == 4'd8) begin
                            state_reg      <= COMMIT;
                            snap_valid_reg <= 1'b1;
                        end else begin
                            state_reg     <= RD_ISSUE;
                            idx_reg       <= idx_reg + 4'd1;
                            bus_start_reg <= 1'b1;
                            bus_addr_reg  <= addr_table[idx_reg + 4'd1];
                        end
                    end
                end
                COMMIT:   state_reg <= IDLE;
                WR_ISSUE: state_reg <= WR_WAIT;
                WR_WAIT: begin
                    // An abandoned write still acknowledges so the requester lets go.
                    if (bus_done || timed_out) begin
                        state_reg  <= IDLE;
                        wr_ack_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // The last read goes straight into the snapshot so all nine values change together.
    always_ff @(posedge reloj_nexys) begin
        if (reset_total) begin
            for (int i = 0; i < 8; i++) shadow_reg[i] <= 8'h00;
            for (int i = 0; i < 9; i++) snap_reg[i] <= 8'h00;
        end else begin
            if (rd_capture && !idx_reg[3])
                shadow_reg[idx_reg[2:0]] <= bus_rdata;
            if (rd_commit) begin
                for (int i = 0; i < 8; i++) snap_reg[i] <= shadow_reg[i];
                snap_reg[8] <= bus_rdata;
            end
        end
    end

    assign bus_start  = bus_start_reg;
    assign bus_rw     = bus_rw_reg;
    assign bus_addr   = bus_addr_reg;
    assign bus_wdata  = bus_wdata_reg;
    assign wr_ack     = wr_ack_reg;
    assign snap_valid = snap_valid_reg;
    assign s_oro      = snap_reg[0];
    assign m_oro      = snap_reg[1];
    assign h_oro      = snap_reg[2];
    assign giorno     = snap_reg[3];
    assign messe      = snap_reg[4];
    assign agno       = snap_reg[5];
    assign secondo    = snap_reg[6];
    assign minute     = snap_reg[7];
    assign ora        = snap_reg[8];

endmodule

// File: tb/tb_rtc_access_scheduler.sv
// Bench for rtc_access_scheduler: bus engine model, transaction-level scoreboard, directed scenarios.
module tb_rtc_access_scheduler;

    localparam int DIV = 64;

    logic       reloj_nexys = 1'b0;
    logic       reset_total = 1'b1;
    logic       wr_req = 1'b0;
    logic [7:0] wr_addr = 8'h00;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] bus_rdata = 8'h00;
    logic       bus_done = 1'b0;
    logic       wr_ack, bus_start, bus_rw, snap_valid, bus_err;
    logic [7:0] bus_addr, bus_wdata;
    logic [7:0] h_oro, m_oro, s_oro, giorno, messe, agno, ora, minute, secondo;

    rtc_access_scheduler #(.REFRESH_DIV(DIV)) dut (
        .reloj_nexys(reloj_nexys), .reset_total(reset_total),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .bus_start(bus_start), .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_done(bus_done),
        .h_oro(h_oro), .m_oro(m_oro), .s_oro(s_oro),
        .giorno(giorno), .messe(messe), .agno(agno),
        .ora(ora), .minute(minute), .secondo(secondo),
        .snap_valid(snap_valid), .bus_err(bus_err)
    );

    initial forever #5 reloj_nexys = ~reloj_nexys;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] tbl(input int k);
        logic [7:0] base;
        case (k / 3)
            0:       base = 8'h21;
            1:       base = 8'h24;
            default: base = 8'h41;
        endcase
        return base + 8'(k % 3);
    endfunction

    // Bus engine: done one cycle after start (optionally 50 cycles for one read of 0x24).
    int         eng_round = 0;
    bit         eng_busy = 0;
    int         eng_left = 0;
    bit         eng_rw = 0;
    logic [7:0] eng_addr = 8'h00;
    bit         delay_once = 0;
    bit         stray_req = 0;

    initial begin
        logic r;
        forever begin
            @(posedge reloj_nexys);
            r = reset_total;
            #1;
            bus_done = 1'b0;
            if (r) begin
                eng_busy = 0;
            end else begin
                if (eng_busy) begin
                    if (eng_left == 0) begin
                        bus_done  = 1'b1;
                        bus_rdata = eng_rw ? (eng_addr ^ 8'((eng_round - 1) << 4)) : 8'h00;
                        eng_busy  = 0;
                    end else begin
                        eng_left--;
                    end
                end else if (stray_req) begin
                    bus_done  = 1'b1;
                    bus_rdata = 8'hEE;
                    stray_req = 0;
                end
                if (bus_start) begin
                    eng_busy = 1;
                    eng_rw   = bus_rw;
                    eng_addr = bus_addr;
                    eng_left = 0;
                    if (bus_rw && bus_addr == 8'h21) eng_round++;
                    if (delay_once && bus_rw && bus_addr == 8'h24) begin
                        eng_left   = 50;
                        delay_once = 0;
                    end
                end
            end
        end
    end

    // Scoreboard: bursts read the 9 table addresses in order and publish all at once.
    initial begin
        logic       rst_s;
        int         pos, last_start;
        bit         outstanding, out_rw, pend_sv, pend_ack, exp_sv, exp_ack;
        bit         prev_wr_req, prev_ack;
        logic [7:0] model_snap [9];
        logic [7:0] shadow     [9];
        logic [7:0] pend_snap  [9];
        logic [7:0] act        [9];
        pos = 0; last_start = -100; outstanding = 0; out_rw = 0;
        pend_sv = 0; pend_ack = 0; prev_wr_req = 0; prev_ack = 0;
        for (int k = 0; k < 9; k++) begin
            model_snap[k] = 8'h00; shadow[k] = 8'h00; pend_snap[k] = 8'h00;
        end
        forever begin
            @(posedge reloj_nexys);
            rst_s = reset_total;
            if (rst_s) cyc = 0; else cyc++;
            @(negedge reloj_nexys);
            if (rst_s) begin
                pos = 0; outstanding = 0; pend_sv = 0; pend_ack = 0; last_start = -100;
                for (int k = 0; k < 9; k++) model_snap[k] = 8'h00;
                check("rst_bus_start", bus_start, 0);
                check("rst_wr_ack", wr_ack, 0);
                check("rst_snap_valid", snap_valid, 0);
                check("rst_bus_rw", bus_rw, 0);
                check("rst_bus_addr", bus_addr, 0);
                check("rst_bus_wdata", bus_wdata, 0);
            end else begin
                exp_sv  = pend_sv;
                exp_ack = pend_ack;
                if (pend_sv) model_snap = pend_snap;
                pend_sv = 0;
                pend_ack = 0;
                check("snap_valid", snap_valid, exp_sv);
                check("wr_ack", wr_ack, exp_ack);
                if (bus_done && outstanding) begin
                    outstanding = 0;
                    if (out_rw) begin
                        shadow[pos] = bus_rdata;
                        pos++;
                        if (pos == 9) begin
                            pend_sv   = 1;
                            pend_snap = shadow;
                            pos       = 0;
                        end
                    end else begin
                        pend_ack = 1;
                    end
                end
                if (bus_start) begin
                    check("start_engine_idle", outstanding, 0);
                    check("start_gap", (cyc - last_start) >= 2, 1);
                    last_start = cyc;
                    if (bus_rw) begin
                        check("rd_addr", bus_addr, tbl(pos));
                        if (pos == 0) check("wr_priority", prev_wr_req && !prev_ack, 0);
                    end else begin
                        check("wr_mid_burst", pos, 0);
                        check("wr_req_held", wr_req, 1);
                        check("wr_addr", bus_addr, wr_addr);
                        check("wr_data", bus_wdata, wr_data);
                    end
                    outstanding = 1;
                    out_rw      = bus_rw;
                end
            end
            act[0] = s_oro;   act[1] = m_oro;  act[2] = h_oro;
            act[3] = giorno;  act[4] = messe;  act[5] = agno;
            act[6] = secondo; act[7] = minute; act[8] = ora;
            for (int k = 0; k < 9; k++) check($sformatf("snap[%0d]", k), act[k], model_snap[k]);
`ifndef RTC_TIMEOUT_EN
            check("bus_err", bus_err, 0);
`endif
            prev_wr_req = wr_req;
            prev_ack    = wr_ack;
        end
    end

    task automatic wait_start(input bit rw, input logic [7:0] a, output int c);
        c = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge reloj_nexys);
            if (bus_start && bus_rw == rw && bus_addr == a) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            n_cmp++; n_err++;
            $display("FAIL wait_start: no start rw=%0d addr=%0h seen, expected one within 300 cycles", rw, a);
        end
    endtask

    task automatic wait_pulse(input bit want_snap, output int c);
        c = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge reloj_nexys);
            if (want_snap ? snap_valid : wr_ack) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            n_cmp++; n_err++;
            $display("FAIL wait_pulse: no %s seen, expected one within 300 cycles",
                     want_snap ? "snap_valid" : "wr_ack");
        end
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < 400; i++) begin
            @(negedge reloj_nexys);
            if (cyc == n) return;
        end
        n_cmp++; n_err++;
        $display("FAIL wait_cyc: cycle %0d not reached, now %0d", n, cyc);
    endtask

    initial begin
        int c;
        repeat (3) @(posedge reloj_nexys);
        #3 reset_total = 1'b0;

        // First refresh: trigger at cycle DIV, start one cycle later, publish 18 after that.
        wait_start(1'b1, 8'h21, c);
        check("t1_first_read_cyc", c, DIV + 1);
        wait_pulse(1'b1, c);
        check("t1_snap_cyc", c, DIV + 19);
        check("t1_h_oro", h_oro, 8'h23);
        check("t1_m_oro", m_oro, 8'h22);
        check("t1_s_oro", s_oro, 8'h21);
        check("t1_giorno", giorno, 8'h24);
        check("t1_messe", messe, 8'h25);
        check("t1_agno", agno, 8'h26);
        check("t1_secondo", secondo, 8'h41);
        check("t1_minute", minute, 8'h42);
        check("t1_ora", ora, 8'h43);

        // Stray bus_done while idle must not disturb anything.
        @(posedge reloj_nexys); #3 stray_req = 1;

        // Write raised so that it and the second trigger are seen on the same edge.
        wait_cyc(2 * DIV - 2);
        @(posedge reloj_nexys); #3;
        wr_req = 1'b1; wr_addr = 8'h22; wr_data = 8'h59;
        wait_start(1'b0, 8'h22, c);
        check("t2_write_cyc", c, 2 * DIV);
        wait_pulse(1'b0, c);
        check("t2_ack_cyc", c, 2 * DIV + 2);
        @(posedge reloj_nexys); #3 wr_req = 1'b0;
        wait_start(1'b1, 8'h21, c);
        check("t2_read_cyc", c, 2 * DIV + 3);
        wait_pulse(1'b1, c);
        check("t2_snap_cyc", c, 2 * DIV + 21);

        // Write raised mid-burst waits until after the commit.
        wait_start(1'b1, 8'h25, c);
        check("t3_idx4_cyc", c, 3 * DIV + 9);
        @(posedge reloj_nexys); #3;
        wr_req = 1'b1; wr_addr = 8'h30; wr_data = 8'h12;
        wait_start(1'b0, 8'h30, c);
        check("t3_write_cyc", c, 3 * DIV + 21);
        wait_pulse(1'b0, c);
        check("t3_ack_cyc", c, 3 * DIV + 23);
        @(posedge reloj_nexys); #3;
        wr_req = 1'b0;
        delay_once = 1;

        // Slow read at idx 3: old snapshot (round 3) held until the late commit.
        wait_start(1'b1, 8'h21, c);
        check("t4_read_cyc", c, 4 * DIV + 1);
        wait_cyc(300);
        check("t4_held_s_oro", s_oro, 8'h01);
        check("t4_held_agno", agno, 8'h06);
        wait_pulse(1'b1, c);
        check("t4_snap_cyc", c, 325);
        check("t4_s_oro", s_oro, 8'h11);
        check("t4_ora", ora, 8'h73);

        // Reset while waiting on read idx 5.
        wait_start(1'b1, 8'h26, c);
        check("t5_idx5_cyc", c, 337);
        @(posedge reloj_nexys); #3 reset_total = 1'b1;
        @(posedge reloj_nexys); #3 reset_total = 1'b0;
        @(negedge reloj_nexys);
        check("t5_h_oro_zero", h_oro, 8'h00);
        check("t5_s_oro_zero", s_oro, 8'h00);
        check("t5_ora_zero", ora, 8'h00);
        check("t5_snap_valid_zero", snap_valid, 0);
        wait_start(1'b1, 8'h21, c);
        check("t5_restart_cyc", c, DIV + 1);
        wait_pulse(1'b1, c);
        check("t5_snap_cyc", c, DIV + 19);

        repeat (3) @(posedge reloj_nexys);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100000 time units, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
